// File: rtl/g4_pkg.sv
// g4_pkg -- shared constants and types for the G4 rule-table update engine.
//   ENTRY_W      : rule word width
//   field offsets: RULEID_LSB / INDEX_LSB, both ID_W bits wide
//   EMPTY_*      : marker for a free table slot
//   OP_* / ST_*  : command op codes and response status codes
//   state_e      : update-engine FSM states
package g4_pkg;

  localparam int ENTRY_W    = 171;
  localparam int ID_W       = 11;
  localparam int ADDR_W     = 11;
  localparam int RULEID_LSB = 11;
  localparam int INDEX_LSB  = 0;

  localparam logic [ID_W-1:0]    EMPTY_RULEID = 11'h7FF;
  // All fields zero except ruleID, which carries the free-slot marker.
  localparam logic [ENTRY_W-1:0] EMPTY_ENTRY  = ENTRY_W'(EMPTY_RULEID) << RULEID_LSB;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_MISS  = 2'd1;  // FULL on insert, NOTFOUND on delete
  localparam logic [1:0] ST_BADID = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CMP  = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_e;

  function automatic logic [ID_W-1:0] rule_id_of(input logic [ENTRY_W-1:0] e);
    return e[RULEID_LSB +: ID_W];
  endfunction

endpackage

// File: rtl/g4_entry_hit.sv
// g4_entry_hit -- decides whether the table word just read is the slot the
// current command is looking for.
//   op_i      : latched command op (insert / delete)
//   rule_id_i : latched ruleID of the command
//   dout_i    : registered table read data
//   hit_o     : insert -> slot is free; delete -> slot holds rule_id_i
module g4_entry_hit
  import g4_pkg::*;
(
  input  logic               op_i,
  input  logic [ID_W-1:0]    rule_id_i,
  input  logic [ENTRY_W-1:0] dout_i,
  output logic               hit_o
);

  logic [ID_W-1:0] dout_id;
  assign dout_id = rule_id_of(dout_i);

  // Only the ruleID field takes part in the compare.
  logic unused_dout;
  assign unused_dout = ^{dout_i[ENTRY_W-1:RULEID_LSB+ID_W], dout_i[RULEID_LSB-1:0]};

  always_comb begin
    hit_o = 1'b0;
    if (op_i == OP_INSERT) hit_o = (dout_id == EMPTY_RULEID);
    else                   hit_o = (dout_id == rule_id_i);
  end

endmodule

// File: rtl/g4_table_updater.sv
// g4_table_updater -- insert/delete engine owning the port of one G4 rule table.
// Each command scans the table from slot 0: insert fills the first free slot,
// delete clears the first slot with a matching ruleID. One response per command.
//   clk, rst                : clock, synchronous active-high reset
//   cmd_valid/ready/op/entry: command handshake (op 0 = insert, 1 = delete)
//   resp_valid/ready        : response handshake
//   resp_status/index       : OK / FULL-NOTFOUND / BADID, slot touched (0 if not OK)
//   tbl_addr/we/din         : table address and write port
//   tbl_dout                : table read data, one cycle after tbl_addr
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// RD     | slot ptr presented on tbl_addr for reading
// CMP    | tbl_dout of slot ptr checked for a hit
// WR     | hit slot written (rule or EMPTY_ENTRY)
// RESP   | response held until resp_ready
module g4_table_updater
  import g4_pkg::*;
#(
  parameter int TABLE_ENTRY_SIZE = 29  // last valid address, at most 2046
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [ENTRY_W-1:0] cmd_entry,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [1:0]         resp_status,
  output logic [ADDR_W-1:0]  resp_index,
  output logic [ADDR_W-1:0]  tbl_addr,
  output logic               tbl_we,
  output logic [ENTRY_W-1:0] tbl_din,
  input  logic [ENTRY_W-1:0] tbl_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TABLE_ENTRY_SIZE);

  state_e                      state_q;
  logic                        op_q;
  // Everything above the index field; the index is always rewritten with ptr.
  logic [ENTRY_W-INDEX_LSB-ID_W-1:0] entry_q;
  logic [ADDR_W-1:0]           ptr_q;
  logic [ADDR_W-1:0]           ptr_d;
  logic                        resp_valid_q;
  logic [1:0]                  resp_status_q;
  logic [ADDR_W-1:0]           resp_index_q;
  logic [ADDR_W-1:0]           tbl_addr_q;
  logic                        tbl_we_q;
  logic [ENTRY_W-1:0]          tbl_din_q;
  logic                        hit;

  logic unused_cmd_index;
  assign unused_cmd_index = ^cmd_entry[INDEX_LSB +: ID_W];

  assign ptr_d = ptr_q + ADDR_W'(1);

  g4_entry_hit u_hit (
    .op_i      (op_q),
    .rule_id_i (entry_q[ID_W-1:0]),
    .dout_i    (tbl_dout),
    .hit_o     (hit)
  );

  // Low throughout reset, high in the very first cycle after it.
  assign cmd_ready   = (state_q == S_IDLE) && !rst;
  assign resp_valid  = resp_valid_q;
  assign resp_status = resp_status_q;
  assign resp_index  = resp_index_q;
  assign tbl_addr    = tbl_addr_q;
  assign tbl_we      = tbl_we_q;
  assign tbl_din     = tbl_din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      op_q          <= OP_INSERT;
      entry_q       <= '0;
      ptr_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_status_q <= ST_OK;
      resp_index_q  <= '0;
      tbl_addr_q    <= '0;
      tbl_we_q      <= 1'b0;
      tbl_din_q     <= '0;
    end else begin
      // tbl_addr/tbl_we are only non-zero in RD/WR; each transition into
      // those states sets them for exactly that cycle.
      tbl_addr_q <= '0;
      tbl_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            entry_q <= cmd_entry[ENTRY_W-1:INDEX_LSB+ID_W];
            ptr_q   <= '0;
            if (rule_id_of(cmd_entry) == EMPTY_RULEID) begin
              resp_valid_q  <= 1'b1;
              resp_status_q <= ST_BADID;
              resp_index_q  <= '0;
              state_q       <= S_RESP;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_CMP;
        S_CMP: begin
          if (hit) begin
            tbl_addr_q <= ptr_q;
            tbl_we_q   <= 1'b1;
            tbl_din_q  <= (op_q == OP_INSERT) ? {entry_q, ptr_q} : EMPTY_ENTRY;
            state_q    <= S_WR;
          end else if (ptr_q == LAST_ADDR) begin
            resp_valid_q  <= 1'b1;
            resp_status_q <= ST_MISS;
            resp_index_q  <= '0;
            state_q       <= S_RESP;
          end else begin
            ptr_q      <= ptr_d;
            tbl_addr_q <= ptr_d;
            state_q    <= S_RD;
          end
        end
        S_WR: begin
          resp_valid_q  <= 1'b1;
          resp_status_q <= ST_OK;
          resp_index_q  <= ptr_q;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_g4_table_updater.sv
module tb_g4_table_updater;

  localparam int TES   = 29;
  localparam int DEPTH = TES + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_op = 1'b0;
  logic [170:0] cmd_entry = '0;
  logic         resp_ready = 1'b0;
  logic         cmd_ready;
  logic         resp_valid;
  logic [1:0]   resp_status;
  logic [10:0]  resp_index;
  logic [10:0]  tbl_addr;
  logic         tbl_we;
  logic [170:0] tbl_din;
  logic [170:0] tbl_dout;

  always #5 clk = ~clk;

  g4_table_updater #(.TABLE_ENTRY_SIZE(TES)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_entry   (cmd_entry),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_status (resp_status),
    .resp_index  (resp_index),
    .tbl_addr    (tbl_addr),
    .tbl_we      (tbl_we),
    .tbl_din     (tbl_din),
    .tbl_dout    (tbl_dout)
  );

  // Table memory with a bench-side load port.
  logic [170:0] mem [0:DEPTH-1];
  logic         bd_we = 1'b0;
  logic [10:0]  bd_addr = '0;
  logic [170:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (tbl_we) mem[tbl_addr] <= tbl_din;
    tbl_dout <= mem[tbl_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [170:0] act, input logic [170:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [10:0] id_of(input logic [170:0] e);
    return e[21:11];
  endfunction

  function automatic logic [170:0] mk(input int id, input int idx);
    return {32'hC0A8_0000 + 32'(id), 6'd24, 32'h0A00_0001, 6'd32,
            16'hFFFF, 16'h0000, 16'd80, 16'd80, 8'd6, 1'b0, 11'(id), 11'(idx)};
  endfunction

  // Reference table and expectations for the command in flight.
  logic [170:0] model_tbl [0:DEPTH-1];
  logic [170:0] empty_e;
  bit           chk_en = 1'b0;
  bit           m_active = 1'b0;
  bit           m_hit, m_scan;
  int           m_t0, m_rs, m_hold, m_we_rel, m_k, m_last, m_status, m_index;
  logic [170:0] m_din;

  task automatic model_cmd(input logic op, input logic [170:0] e, input int hold);
    int k;
    k = -1;
    m_hit = 1'b0;
    m_we_rel = -1;
    m_k = 0;
    if (id_of(e) == 11'h7FF) begin
      m_scan = 1'b0; m_status = 2; m_index = 0; m_rs = 1; m_last = -1;
    end else begin
      m_scan = 1'b1;
      for (int i = 0; i < DEPTH; i++)
        if (k < 0 && ((op == 1'b0 && id_of(model_tbl[i]) == 11'h7FF) ||
                      (op == 1'b1 && id_of(model_tbl[i]) == id_of(e))))
          k = i;
      if (k >= 0) begin
        m_hit = 1'b1; m_k = k; m_last = k; m_status = 0; m_index = k;
        m_we_rel = 2 * (k + 1) + 1;
        m_rs = 2 * (k + 1) + 2;
        m_din = op ? empty_e : {e[170:11], 11'(k)};
      end else begin
        m_last = TES; m_status = 1; m_index = 0;
        m_rs = 2 * (TES + 1) + 1;
      end
    end
    m_hold = hold;
  endtask

  task automatic run_cmd(input logic op, input logic [170:0] e, input int hold,
                         input int lit_st, input int lit_idx, input int lit_rs);
    int guard;
    model_cmd(op, e, hold);
    check("model_status", 171'(m_status), 171'(lit_st));
    check("model_index", 171'(m_index), 171'(lit_idx));
    check("model_resp_cycle", 171'(m_rs), 171'(lit_rs));
    tick();
    check("cmd_ready_before_cmd", cmd_ready, 1'b1);
    m_t0 = cyc;
    m_active = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_entry = e;
    resp_ready = (hold == 0);
    tick();
    cmd_valid = 1'b0;
    guard = 0;
    while ((cyc - m_t0) <= m_rs + m_hold && guard < 300) begin
      if ((cyc - m_t0) == m_rs + m_hold) resp_ready = 1'b1;
      tick();
      guard++;
    end
    if (guard >= 300) check("cmd_timeout", 1'b0, 1'b1);
    m_active = 1'b0;
    resp_ready = 1'b0;
    if (m_hit) model_tbl[m_k] = m_din;
  endtask

  task automatic bd_write(input int a, input logic [170:0] d);
    bd_addr = 11'(a);
    bd_data = d;
    bd_we = 1'b1;
    tick();
    bd_we = 1'b0;
    model_tbl[a] = d;
  endtask

  // Per-cycle compare against the model.
  int c_rel, c_addr;
  bit c_rv, c_cr, c_we;
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_active) begin
        c_rel = cyc - m_t0;
        c_rv = (c_rel >= m_rs) && (c_rel <= m_rs + m_hold);
        c_cr = (c_rel > m_rs + m_hold);
        c_we = m_hit && (c_rel == m_we_rel);
        c_addr = 0;
        if (m_scan && (c_rel % 2) == 1 && (c_rel - 1) / 2 <= m_last) c_addr = (c_rel - 1) / 2;
        if (c_we) c_addr = m_k;
        check("resp_valid", resp_valid, c_rv);
        check("cmd_ready", cmd_ready, c_cr);
        check("tbl_we", tbl_we, c_we);
        check("tbl_addr", tbl_addr, 171'(c_addr));
        if (c_we) check("tbl_din", tbl_din, m_din);
        if (c_rv) begin
          check("resp_status", resp_status, 171'(m_status));
          check("resp_index", resp_index, 171'(m_index));
        end
      end else begin
        check("idle_cmd_ready", cmd_ready, 1'b1);
        check("idle_resp_valid", resp_valid, 1'b0);
        check("idle_tbl_we", tbl_we, 1'b0);
        check("idle_tbl_addr", tbl_addr, 11'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    empty_e = '0;
    empty_e[21:11] = 11'h7FF;
    for (int i = 0; i < DEPTH; i++) bd_write(i, empty_e);

    // Reset values, held in reset for the whole table load.
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_status", resp_status, 2'd0);
    check("rst_resp_index", resp_index, 11'd0);
    check("rst_tbl_we", tbl_we, 1'b0);
    check("rst_tbl_addr", tbl_addr, 11'd0);
    check("rst_tbl_din", tbl_din, 171'd0);
    rst = 1'b0;
    tick();
    check("cmd_ready_after_rst", cmd_ready, 1'b1);
    chk_en = 1'b1;

    // Inserts into an empty table: slots 0..3.
    run_cmd(1'b0, mk(5, 11'h123), 0, 0, 0, 4);
    check("mem0_insert", mem[0], {mk(5, 0)});
    run_cmd(1'b0, mk(6, 0), 0, 0, 1, 6);
    run_cmd(1'b0, mk(7, 0), 0, 0, 2, 8);
    run_cmd(1'b0, mk(9, 77), 0, 0, 3, 10);
    check("mem3_insert", mem[3], {mk(9, 3)});

    // Delete found at slot 7, then the same delete again misses.
    bd_write(7, mk(12, 7));
    run_cmd(1'b1, mk(12, 5), 0, 0, 7, 18);
    check("mem7_cleared", mem[7], empty_e);
    run_cmd(1'b1, mk(12, 0), 0, 1, 0, 61);

    // Reserved ruleID.
    run_cmd(1'b0, mk(11'h7FF, 0), 0, 2, 0, 1);

    // Response back-pressure for 5 cycles.
    run_cmd(1'b0, mk(20, 0), 5, 0, 4, 12);

    // Full table, then delete of the last slot.
    for (int i = 5; i < DEPTH; i++) bd_write(i, mk(100 + i, i));
    run_cmd(1'b0, mk(40, 0), 0, 1, 0, 61);
    run_cmd(1'b1, mk(129, 0), 0, 0, 29, 62);
    check("mem29_cleared", mem[29], empty_e);

    // Reset during a scan while slot 10 is being read.
    bd_write(29, mk(129, 29));
    bd_write(20, empty_e);
    model_cmd(1'b0, mk(30, 0), 0);
    tick();
    m_t0 = cyc;
    m_active = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = 1'b0;
    cmd_entry = mk(30, 0);
    resp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    guard = 0;
    while ((cyc - m_t0) < 21 && guard < 50) begin
      tick();
      guard++;
    end
    check("abort_addr_ptr10", tbl_addr, 11'd10);
    rst = 1'b1;
    chk_en = 1'b0;
    tick();
    check("abort_cmd_ready_in_rst", cmd_ready, 1'b0);
    check("abort_tbl_we", tbl_we, 1'b0);
    check("abort_resp_valid", resp_valid, 1'b0);
    check("abort_tbl_addr", tbl_addr, 11'd0);
    rst = 1'b0;
    m_active = 1'b0;
    resp_ready = 1'b0;
    tick();
    check("abort_idle_after", cmd_ready, 1'b1);
    chk_en = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    check("abort_mem20_untouched", mem[20], empty_e);
    check("abort_mem21_untouched", mem[21], model_tbl[21]);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
